bcd_scan_display: RTL

Four-digit multiplexed seven-segment driver that sits directly downstream of the BCD down-counter chain. It takes the packed BCD digits and the chain's zero/borrow flag and scans one common-anode digit per slot. Leading zeros can be blanked, and the whole display blinks while the count is at zero. Data is snapshotted once per frame so a digit never changes partway through a scan.

---
 rtl/bcd_scan_display.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bcd_scan_display.sv
// Four-digit common-anode seven-segment scanner with per-frame snapshot, leading-zero blanking and zero blink.
// All outputs registered; a slot loads on each prescaler tick, no backpressure.
module bcd_scan_display #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic        clk,
  input  logic        mr,
  input  logic [15:0] d,
  input  logic        zero,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int unsigned PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BMOD = 2 * BLINK_DIV;
  localparam int unsigned BW   = (BMOD > 1) ? $clog2(BMOD) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BMOD - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_DIV);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [15:0]   snap_q, snap_d;
  logic          zsnap_q, zsnap_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          fstart;
  logic [3:0]    digit;
  logic          lz;
  logic          blink_off;
  logic          blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    fstart  = tick && (ptr_q == 2'd0);
    presc_d = tick ? '0 : presc_q + PW'(1);
    ptr_d   = tick ? ptr_q + 2'd1 : ptr_q;
    snap_d  = fstart ? d : snap_q;
    zsnap_d = fstart ? zero : zsnap_q;
    blink_d = blink_q;
    if (fstart) begin
      if (!zero || (blink_q == BLINK_LAST)) blink_d = '0;
      else                                  blink_d = blink_q + BW'(1);
    end

    // Slot 0 sees the freshly snapped values because *_d is used here.
    digit = snap_d[3:0];
    lz    = 1'b0;
    case (ptr_q)
      2'd0: begin
        digit = snap_d[3:0];
        lz    = 1'b0;
      end
      2'd1: begin
        digit = snap_d[7:4];
        lz    = (snap_d[15:4] == 12'h000);
      end
      2'd2: begin
        digit = snap_d[11:8];
        lz    = (snap_d[15:8] == 8'h00);
      end
      default: begin
        digit = snap_d[15:12];
        lz    = (snap_d[15:12] == 4'h0);
      end
    endcase

    blink_off = zsnap_d && (blink_d >= BLINK_HALF);
    blank     = (blank_lz && lz) || blink_off;

    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      if (blank) begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
      end else begin
        an_d  = ~(4'b0001 << ptr_q);
        seg_d = seg_decode(digit);
      end
    end
    frame_d = tick && (ptr_q == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (mr) begin
      presc_q <= '0;
      ptr_q   <= '0;
      snap_q  <= '0;
      zsnap_q <= 1'b0;
      blink_q <= '0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
      zsnap_q <= zsnap_d;
      blink_q <= blink_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;
  assign frame = frame_q;

endmodule
